// File: rtl/rpn_stack_ctrl.sv
// rtl/rpn_stack_ctrl.sv - RPN stack controller with PUSH/POP/ADD/SUB/MUL/SWAP/DUP/CLR
// Optional multiplier built only when RPN_STACK_MUL_EN is defined.
module rpn_stack_ctrl #(
  parameter int k     = 16,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [2:0]                   cmd_op,
  input  logic [k-1:0]                 cmd_data,
  output logic [k-1:0]                 top,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full,
  output logic                         err,
  output logic                         err_sticky
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] OP_PUSH = 3'b000;
  localparam logic [2:0] OP_POP  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_SWAP = 3'b101;
  localparam logic [2:0] OP_DUP  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t         state;
  logic [2:0]     op_q;
  logic [k-1:0]   a;
  logic [k-1:0]   b;
  logic [k-1:0]   mem [DEPTH];

  logic [AW-1:0]  idx_cnt;
  logic [AW-1:0]  idx_m1;
  logic [AW-1:0]  idx_m2;
  logic           legal;
  logic           binary;
  logic           two_plus;
  logic [k-1:0]   mul_res;

  assign idx_cnt  = count[AW-1:0];
  assign idx_m1   = AW'(count - CW'(1));
  assign idx_m2   = AW'(count - CW'(2));
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign two_plus = (count >= CW'(2));
  assign top      = empty ? '0 : mem[idx_m1];

`ifdef RPN_STACK_MUL_EN
  assign mul_res = a * b;
`else
  assign mul_res = '0;
`endif

  // Legality is judged purely on the current depth; illegal commands never leave IDLE.
  always_comb begin
    legal  = 1'b1;
    binary = 1'b0;
    case (cmd_op)
      OP_PUSH: legal = !full;
      OP_POP:  legal = !empty;
      OP_ADD,
      OP_SUB,
      OP_SWAP: begin
        legal  = two_plus;
        binary = 1'b1;
      end
      OP_MUL: begin
`ifdef RPN_STACK_MUL_EN
        legal  = two_plus;
`else
        legal  = 1'b0;
`endif
        binary = 1'b1;
      end
      OP_DUP:  legal = !empty && !full;
      OP_CLR:  legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cmd_ready  <= 1'b1;
      count      <= '0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      op_q       <= OP_PUSH;
      a          <= '0;
      b          <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            if (!legal) begin
              err        <= 1'b1;
              err_sticky <= 1'b1;
            end else if (binary) begin
              op_q      <= cmd_op;
              state     <= FETCH;
              cmd_ready <= 1'b0;
            end else begin
              case (cmd_op)
                OP_PUSH: begin
                  mem[idx_cnt] <= cmd_data;
                  count        <= count + CW'(1);
                end
                OP_POP:  count <= count - CW'(1);
                OP_DUP: begin
                  mem[idx_cnt] <= mem[idx_m1];
                  count        <= count + CW'(1);
                end
                OP_CLR: begin
                  count      <= '0;
                  err_sticky <= 1'b0;
                end
                default: ;
              endcase
            end
          end
        end
        FETCH: begin
          a     <= mem[idx_m2];
          b     <= mem[idx_m1];
          state <= WRITE;
        end
        WRITE: begin
          case (op_q)
            OP_ADD: begin
              mem[idx_m2] <= a + b;
              count       <= count - CW'(1);
            end
            OP_SUB: begin
              mem[idx_m2] <= a - b;
              count       <= count - CW'(1);
            end
            OP_MUL: begin
              mem[idx_m2] <= mul_res;
              count       <= count - CW'(1);
            end
            OP_SWAP: begin
              mem[idx_m2] <= b;
              mem[idx_m1] <= a;
            end
            default: ;
          endcase
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// tb/tb_rpn_stack_ctrl.sv - directed self-checking bench for rpn_stack_ctrl
module tb_rpn_stack_ctrl;

  localparam logic [2:0] OP_PUSH = 3'b000;
  localparam logic [2:0] OP_POP  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_SWAP = 3'b101;
  localparam logic [2:0] OP_DUP  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_data;
  logic [15:0] top;
  logic [3:0]  count;
  logic        empty;
  logic        full;
  logic        err;
  logic        err_sticky;

  int checks = 0;
  int errors = 0;

  rpn_stack_ctrl #(.k(16), .DEPTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .top        (top),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .err        (err),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [15:0] data);
    int n = 0;
    while (!cmd_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!cmd_ready) check("ready_timeout", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 3'($urandom);
    cmd_data  = 16'($urandom);
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = OP_PUSH;
    cmd_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    check("rst_top",    top,        0);
    check("rst_count",  count,      0);
    check("rst_empty",  empty,      1);
    check("rst_full",   full,       0);
    check("rst_ready",  cmd_ready,  1);
    check("rst_err",    err,        0);
    check("rst_sticky", err_sticky, 0);

    // 5 3 SUB -> 2
    do_cmd(OP_PUSH, 16'd5);
    do_cmd(OP_PUSH, 16'd3);
    check("p53_top",   top,   3);
    check("p53_count", count, 2);
    do_cmd(OP_SUB, 16'h1234);
    check("sub_busy",  cmd_ready, 0);
    check("sub_err0",  err,       0);
    step(1);
    check("sub_err1",  err,       0);
    check("sub_mid_count", count, 2);
    step(1);
    check("sub_top",    top,        2);
    check("sub_count",  count,      1);
    check("sub_ready",  cmd_ready,  1);
    check("sub_sticky", err_sticky, 0);

    // modulo add wrap
    do_cmd(OP_CLR, 16'h0);
    do_cmd(OP_PUSH, 16'hFFFF);
    do_cmd(OP_PUSH, 16'h0002);
    do_cmd(OP_ADD, 16'h0);
    step(2);
    check("wrap_top",   top,   16'h0001);
    check("wrap_count", count, 1);

    // fill, overflow, clear
    do_cmd(OP_CLR, 16'h0);
    for (int i = 1; i <= 8; i++) do_cmd(OP_PUSH, 16'(i * 16'h11));
    check("fill_full",  full,  1);
    check("fill_count", count, 8);
    check("fill_top",   top,   16'h88);
    do_cmd(OP_PUSH, 16'hAAAA);
    check("ovf_err",    err,        1);
    check("ovf_sticky", err_sticky, 1);
    check("ovf_count",  count,      8);
    check("ovf_top",    top,        16'h88);
    check("ovf_ready",  cmd_ready,  1);
    step(1);
    check("ovf_err_end", err,        0);
    check("ovf_sticky2", err_sticky, 1);
    do_cmd(OP_CLR, 16'h0);
    check("clr_count",  count,      0);
    check("clr_sticky", err_sticky, 0);
    check("clr_empty",  empty,      1);

    // empty / underflow cases, DUP
    do_cmd(OP_POP, 16'h0);
    check("pop_empty_err",   err,   1);
    check("pop_empty_count", count, 0);
    step(1);
    check("pop_empty_err_end", err, 0);
    do_cmd(OP_PUSH, 16'd7);
    check("push7_err", err, 0);
    do_cmd(OP_ADD, 16'h0);
    check("add1_err",   err,       1);
    check("add1_count", count,     1);
    check("add1_top",   top,       7);
    check("add1_ready", cmd_ready, 1);
    do_cmd(OP_DUP, 16'h0);
    check("dup_count", count, 2);
    check("dup_top",   top,   7);
    check("dup_err",   err,   0);
    do_cmd(OP_POP, 16'h0);
    check("pop_count", count, 1);

    // SWAP then reset during FETCH of ADD
    do_cmd(OP_CLR, 16'h0);
    do_cmd(OP_PUSH, 16'd4);
    do_cmd(OP_PUSH, 16'd9);
    do_cmd(OP_SWAP, 16'h0);
    step(2);
    check("swap_top",   top,   4);
    check("swap_count", count, 2);
    do_cmd(OP_POP, 16'h0);
    check("swap_entry0", top, 9);
    do_cmd(OP_PUSH, 16'd1);
    do_cmd(OP_ADD, 16'h0);
    check("abort_busy", cmd_ready, 0);
    reset = 1'b1;
    #1;
    check("abort_count_async", count, 0);
    check("abort_empty_async", empty, 1);
    #3;
    reset = 1'b0;
    step(3);
    check("abort_count", count,     0);
    check("abort_top",   top,       0);
    check("abort_ready", cmd_ready, 1);
    check("abort_err",   err,       0);

    // MUL, built or rejected
    do_cmd(OP_PUSH, 16'd3);
    do_cmd(OP_PUSH, 16'd5);
    do_cmd(OP_MUL, 16'h0);
`ifdef RPN_STACK_MUL_EN
    check("mul_err0", err, 0);
    step(2);
    check("mul_top",   top,   15);
    check("mul_count", count, 1);
`else
    check("mul_err",    err,   1);
    check("mul_count",  count, 2);
    check("mul_top",    top,   5);
    check("mul_sticky", err_sticky, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
